instr_fetch_unit: RTL and testbench

//  Reads the program counter and fetches instructions from instruction memory.

---
 rtl/mips16_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/instr_fetch_unit.sv | 121 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mips16_pkg.sv
// Shared types and constants for the MIPS16-style fetch front end.
// Widths here fix the layout of the instruction buffer entries.
package mips16_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 16;
  localparam int PC_STEP = 2;
  localparam logic [PC_W-1:0] RESET_PC = 32'h0;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries between the memory response path and decode.
// A flush empties the buffer and wins over a push or pop in the same cycle.
module fetch_fifo
  import mips16_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  fetch_entry_t               i_pushData,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output fetch_entry_t               o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty,
  output logic                       o_full
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == CNT_W'(DEPTH));
  assign o_count  = r_count;
  assign o_head   = r_mem[r_rdPtr];
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_doPush) - CNT_W'(w_doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush && !i_flush) r_mem[r_wrPtr] <= i_pushData;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues credit-limited in-order requests,
// buffers responses and hands {instr, pc} to decode; redirects flush in-flight work.
module instr_fetch_unit
  import mips16_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic [PC_W-1:0]    fetch_pc
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam logic [PC_W-1:0] PC_ALIGN_MASK = ~PC_W'(1);

  fetch_state_e     r_state;
  fetch_state_e     w_nextState;
  logic [PC_W-1:0]  r_fetchPc;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_dropCnt;

  logic [CNT_W-1:0] w_fifoCount;
  logic             w_fifoEmpty;
  logic             w_fifoFull;
  fetch_entry_t     w_head;
  fetch_entry_t     w_pushEntry;
  logic             w_rspAccept;
  logic [CNT_W-1:0] w_outAfterRsp;
  logic [CNT_W-1:0] w_dropAfterRsp;
  logic [SUM_W-1:0] w_inUse;
  logic             w_credit;
  logic             w_reqFire;
  logic             w_push;
  logic             w_pop;
  logic [PC_W-1:0]  w_rspPc;

  assign w_rspAccept    = imem_rsp_valid && (r_outstanding != '0);
  assign w_outAfterRsp  = r_outstanding - CNT_W'(w_rspAccept);
  assign w_dropAfterRsp = r_dropCnt - CNT_W'(imem_rsp_valid && (r_dropCnt != '0));
  assign w_inUse        = SUM_W'(w_fifoCount) + SUM_W'(r_outstanding);
  assign w_credit       = !w_fifoFull && (w_inUse < SUM_W'(FIFO_DEPTH));
  assign w_reqFire      = imem_req_valid && imem_req_ready;
  assign w_pop          = if_valid && if_ready;
  assign w_push         = (r_state == FETCH) && w_rspAccept && !redirect_valid;

  // Outstanding requests in FETCH are always the most recent sequential ones,
  // so the oldest response's PC is recovered by stepping back from fetch_pc.
  assign w_rspPc     = r_fetchPc - (PC_W'(r_outstanding) * PC_W'(PC_STEP));
  assign w_pushEntry = '{instr: imem_rsp_data, pc: w_rspPc};

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_pushData(w_pushEntry),
    .i_pop     (w_pop),
    .i_flush   (redirect_valid),
    .o_head    (w_head),
    .o_count   (w_fifoCount),
    .o_empty   (w_fifoEmpty),
    .o_full    (w_fifoFull)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (redirect_valid) begin
      w_nextState = (w_outAfterRsp != '0) ? FLUSH : FETCH;
    end else if (r_state == FLUSH && w_dropAfterRsp == '0) begin
      w_nextState = FETCH;
    end
  end

  // Request valid is masked during reset so outputs show reset values immediately.
  always_comb begin
    imem_req_valid = 1'b0;
    if (!reset && r_state == FETCH && !redirect_valid) imem_req_valid = w_credit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetchPc     <= RESET_PC;
      r_outstanding <= '0;
      r_dropCnt     <= '0;
    end else begin
      r_outstanding <= w_outAfterRsp + CNT_W'(w_reqFire);
      if (redirect_valid) begin
        r_fetchPc <= redirect_pc & PC_ALIGN_MASK;
        r_dropCnt <= w_outAfterRsp;
      end else begin
        if (w_reqFire) r_fetchPc <= r_fetchPc + PC_W'(PC_STEP);
        if (r_state == FLUSH) r_dropCnt <= w_dropAfterRsp;
      end
    end
  end

  assign imem_req_addr = r_fetchPc;
  assign fetch_pc      = r_fetchPc;
  assign if_valid      = !w_fifoEmpty;
  assign if_instr      = w_fifoEmpty ? '0 : w_head.instr;
  assign if_pc         = w_fifoEmpty ? '0 : w_head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized bench for instr_fetch_unit against a queue-based model
// of requests in flight, the decode buffer, and the fetch PC.
module tb_instr_fetch_unit;
  import mips16_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        reqValid;
  logic        reqReady;
  logic [31:0] reqAddr;
  logic        rspValid;
  logic [15:0] rspData;
  logic        ifValid;
  logic        ifReady;
  logic [15:0] ifInstr;
  logic [31:0] ifPc;
  logic [31:0] fetchPc;

  int checks   = 0;
  int failures = 0;
  int fireCount;

  typedef struct packed {
    logic [31:0] pc;
    logic        drop;
  } infl_t;

  infl_t       inflQ[$];
  logic [31:0] fifoPcQ[$];
  logic [31:0] memQ[$];
  logic [31:0] mPc;

  instr_fetch_unit #(.FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_valid(redirectValid),
    .redirect_pc   (redirectPc),
    .imem_req_valid(reqValid),
    .imem_req_ready(reqReady),
    .imem_req_addr (reqAddr),
    .imem_rsp_valid(rspValid),
    .imem_rsp_data (rspData),
    .if_valid      (ifValid),
    .if_ready      (ifReady),
    .if_instr      (ifInstr),
    .if_pc         (ifPc),
    .fetch_pc      (fetchPc)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] memFn(input logic [31:0] a);
    return a[16:1] ^ a[31:16] ^ 16'h5A3C;
  endfunction

  function automatic bit modelFlushing();
    foreach (inflQ[i]) if (inflQ[i].drop) return 1'b1;
    return 1'b0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs, then advance the model past the edge.
  task automatic applyStimulus(input bit redir, input logic [31:0] tgt, input bit rdy,
                               input bit ifr, input bit rspEn);
    bit    expReq;
    bit    fire;
    bit    pop;
    bit    rsp;
    bit    dutFire;
    infl_t e;
    redirectValid = redir;
    redirectPc    = tgt;
    reqReady      = rdy;
    ifReady       = ifr;
    rspValid      = rspEn && (memQ.size() > 0);
    rspData       = rspValid ? memFn(memQ[0]) : 16'h0;
    #1;
    expReq = !redir && !modelFlushing() && ((fifoPcQ.size() + inflQ.size()) < DEPTH);
    checkOutput("req_valid", 32'(reqValid), 32'(expReq));
    checkOutput("req_addr", reqAddr, mPc);
    checkOutput("fetch_pc", fetchPc, mPc);
    checkOutput("if_valid", 32'(ifValid), 32'(fifoPcQ.size() > 0));
    if (fifoPcQ.size() > 0) begin
      checkOutput("if_pc", ifPc, fifoPcQ[0]);
      checkOutput("if_instr", 32'(ifInstr), 32'(memFn(fifoPcQ[0])));
    end
    fire    = expReq && rdy;
    pop     = (fifoPcQ.size() > 0) && ifr;
    rsp     = rspValid;
    dutFire = reqValid && rdy;
    if (rsp) void'(memQ.pop_front());
    if (dutFire) begin
      memQ.push_back(reqAddr);
      fireCount++;
    end
    @(posedge clk);
    #1;
    if (pop) void'(fifoPcQ.pop_front());
    if (rsp && inflQ.size() > 0) begin
      e = inflQ.pop_front();
      if (!e.drop) fifoPcQ.push_back(e.pc);
    end
    if (redir) begin
      fifoPcQ.delete();
      foreach (inflQ[i]) inflQ[i].drop = 1'b1;
      mPc = tgt & 32'hFFFF_FFFE;
    end else if (fire) begin
      inflQ.push_back('{pc: mPc, drop: 1'b0});
      mPc = mPc + 32'd2;
    end
  endtask

  // Asynchronous reset: outputs must show reset values before any clock edge.
  task automatic doReset();
    reset         = 1'b1;
    redirectValid = 1'b0;
    redirectPc    = 32'h0;
    reqReady      = 1'b0;
    ifReady       = 1'b0;
    rspValid      = 1'b0;
    rspData       = 16'h0;
    #1;
    checkOutput("rst_req_valid", 32'(reqValid), 32'h0);
    checkOutput("rst_if_valid", 32'(ifValid), 32'h0);
    checkOutput("rst_if_instr", 32'(ifInstr), 32'h0);
    checkOutput("rst_if_pc", ifPc, 32'h0);
    checkOutput("rst_req_addr", reqAddr, RESET_PC);
    checkOutput("rst_fetch_pc", fetchPc, RESET_PC);
    inflQ.delete();
    fifoPcQ.delete();
    memQ.delete();
    mPc       = RESET_PC;
    fireCount = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b0;
    redirectValid = 1'b0;
    redirectPc    = 32'h0;
    reqReady      = 1'b0;
    ifReady       = 1'b0;
    rspValid      = 1'b0;
    rspData       = 16'h0;
    #2;

    $display("[TB] step 1: streaming from reset");
    doReset();
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    $display("[TB] step 2: decode stalled");
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    checkOutput("stall_req_count", 32'(fireCount), 32'd4);
    checkOutput("stall_head_pc", ifPc, 32'h0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    $display("[TB] step 3: redirect with two in flight");
    doReset();
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0000_0101, 1'b1, 1'b1, 1'b0);
    checkOutput("flush_req_valid", 32'(reqValid), 32'h0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    $display("[TB] step 4: redirect with response and pop");
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0000_0400, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    $display("[TB] step 5: fetch PC wrap");
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    $display("[TB] step 6: reset while busy");
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    $display("[TB] step 7: randomized traffic");
    for (int i = 0; i < 500; i++) begin
      logic [31:0] tgt;
      bit          redir;
      redir = ($urandom_range(0, 19) == 0);
      tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7)))
                                          : 32'($urandom);
      applyStimulus(redir, tgt, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
